// File: rtl/hd_beat_gen_if.sv
// Bus bundle between the HD-CPU controller and the beat generator.
// The STEP line exists only when HD_BEAT_STEP_EN is defined.
interface hd_beat_gen_if #(
  parameter int CYC_W = 8
);
  logic             QD;
  logic             SHORT;
  logic             LONG;
  logic             STOP;
`ifdef HD_BEAT_STEP_EN
  logic             STEP;
`endif
  logic [3:1]       W;
  logic             RUN;
  logic             CYC_END;
  logic [CYC_W-1:0] CYC_CNT;

`ifdef HD_BEAT_STEP_EN
  modport master (output QD, SHORT, LONG, STOP, STEP, input W, RUN, CYC_END, CYC_CNT);
  modport slave  (input QD, SHORT, LONG, STOP, STEP, output W, RUN, CYC_END, CYC_CNT);
`else
  modport master (output QD, SHORT, LONG, STOP, input W, RUN, CYC_END, CYC_CNT);
  modport slave  (input QD, SHORT, LONG, STOP, output W, RUN, CYC_END, CYC_CNT);
`endif
endinterface

// File: rtl/hd_beat_gen.sv
// HD-CPU beat (W-phase) generator: one-hot W[3:1], cycle shaping and cycle counter.
// Optional single-cycle mode is compiled in with HD_BEAT_STEP_EN.
module hd_beat_gen #(
  parameter int CYC_W = 8
) (
  input  logic          T3,
  input  logic          CLR,
  hd_beat_gen_if.slave  bus
);

  // One-hot encoding lets the state register drive W directly.
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    B1   = 3'b001,
    B2   = 3'b010,
    B3   = 3'b100
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             q0_r;
  logic             q1_r;
  logic             start_s;
  logic             cyc_end_s;
  logic             halt_s;
  logic [CYC_W-1:0] cnt_r;

  assign start_s = q0_r & ~q1_r;

`ifdef HD_BEAT_STEP_EN
  assign halt_s = bus.STOP | bus.STEP;
`else
  assign halt_s = bus.STOP;
`endif

  // QD edge sampler
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      q0_r <= 1'b0;
      q1_r <= 1'b0;
    end else begin
      q0_r <= bus.QD;
      q1_r <= q0_r;
    end
  end

  // Beat state register
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-beat decode and end-of-cycle detection
  always_comb begin
    next_state_s = state_r;
    cyc_end_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) next_state_s = B1;
        else         next_state_s = IDLE;
      end
      B1: begin
        if (bus.SHORT) cyc_end_s    = 1'b1;
        else           next_state_s = B2;
      end
      B2: begin
        if (bus.LONG) next_state_s = B3;
        else          cyc_end_s    = 1'b1;
      end
      B3: begin
        cyc_end_s = 1'b1;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    // No idle beat between cycles unless a halt is requested on the final beat.
    if (cyc_end_s) begin
      if (halt_s) next_state_s = IDLE;
      else        next_state_s = B1;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // Completed-cycle counter, wraps modulo 2^CYC_W
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      cnt_r <= {CYC_W{1'b0}};
    end else if (cyc_end_s) begin
      cnt_r <= cnt_r + CYC_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.W       = state_r;
  assign bus.RUN     = (state_r != IDLE);
  assign bus.CYC_END = cyc_end_s;
  assign bus.CYC_CNT = cnt_r;

endmodule
